// File: rtl/vid_pkg.sv
// Shared definitions for the video PLL lock supervisor.
//   - vid_state_e : supervisor FSM states
//   - DEF_*       : default cycle constants for the supervisor parameters
//   - cnt_width() : width of the shared cycle counter
package vid_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } vid_state_e;

  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_STABLE_CYCLES  = 4096;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_RETRY_MAX      = 3;

  // The shared counter only ever holds values up to (limit - 1). The
  // result is clamped to at least 1 bit so that all limits equal to 1
  // still yield a legal vector.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/vid_pll_ctrl_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings
// (PLL primitive and video pipeline).
//   pll_locked    : PLL LOCK, asynchronous to the supervisor clock
//   pll_resetb    : PLL RESETB, 0 holds the PLL in reset
//   vid_rst       : video-domain reset request, active-high
//   ready         : PLL qualified and vid_rst released
//   fault         : sticky, repeated lock timeouts
//   retries       : timed-out attempts since the last successful lock
//   lock_loss_cnt : saturating count of lock losses while running
//                   (only when VID_PLL_CTRL_STATS_EN is defined)
// modport master : the supervisor; modport slave : the consumer side.
interface vid_pll_ctrl_if;

  logic       pll_locked;
  logic       pll_resetb;
  logic       vid_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retries;
`ifdef VID_PLL_CTRL_STATS_EN
  logic [7:0] lock_loss_cnt;

  modport master (
    input  pll_locked,
    output pll_resetb, vid_rst, ready, fault, retries, lock_loss_cnt
  );
  modport slave (
    output pll_locked,
    input  pll_resetb, vid_rst, ready, fault, retries, lock_loss_cnt
  );
`else
  modport master (
    input  pll_locked,
    output pll_resetb, vid_rst, ready, fault, retries
  );
  modport slave (
    output pll_locked,
    input  pll_resetb, vid_rst, ready, fault, retries
  );
`endif

endinterface

// File: rtl/sync2.sv
// Generic 2-flop synchroniser for a single-bit level signal.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   i_d : asynchronous input
//   o_q : synchronised output (2 cycles of latency)
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vid_pll_ctrl.sv
// Video PLL lock supervisor and reset sequencer.
// Runs on the free-running PLL reference clock, pulses the PLL reset,
// qualifies LOCK for a stable period before releasing the video reset,
// re-pulses the PLL on lock loss or timeout and latches a fault after
// RETRY_MAX consecutive timeouts.
// Ports:
//   clk : reference clock
//   rst : synchronous active-high reset
//   bus : vid_pll_ctrl_if.master (pll_locked in; pll_resetb, vid_rst,
//         ready, fault, retries and optional lock_loss_cnt out)
// Build option: define VID_PLL_CTRL_STATS_EN to include the 8-bit
// saturating lock-loss counter and its lock_loss_cnt output.
module vid_pll_ctrl
  import vid_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RETRY_MAX      = DEF_RETRY_MAX
) (
  input logic            clk,
  input logic            rst,
  vid_pll_ctrl_if.master bus
);

  localparam int CNT_W = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIM   = 2'(RETRY_MAX);

  logic       w_lock_s;
  logic [1:0] w_retries_inc;

  vid_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_resetb;
  logic             r_vid_rst;
  logic             r_ready;
  logic             r_fault;
  logic [1:0]       r_retries;

  sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.pll_locked),
    .o_q (w_lock_s)
  );

  assign w_retries_inc = r_retries + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RESET_PLL;
      r_cnt        <= '0;
      r_pll_resetb <= 1'b0;
      r_vid_rst    <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_retries    <= 2'd0;
    end else begin
      case (r_state)
        RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_pll_resetb <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a timeout expiring on the same cycle.
          if (w_lock_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_retries    <= w_retries_inc;
            r_cnt        <= '0;
            r_pll_resetb <= 1'b0;
            if (w_retries_inc == RETRY_LIM) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= RESET_PLL;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STABLE: begin
          // A drop while qualifying restarts the timeout without a retry.
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_retries <= 2'd0;
            r_vid_rst <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            r_state      <= RESET_PLL;
            r_cnt        <= '0;
            r_pll_resetb <= 1'b0;
            r_vid_rst    <= 1'b1;
            r_ready      <= 1'b0;
          end
        end
        FAULT: begin
          // Parked until rst; outputs already hold the fault values.
        end
        default: begin
          r_state      <= RESET_PLL;
          r_cnt        <= '0;
          r_pll_resetb <= 1'b0;
          r_vid_rst    <= 1'b1;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_resetb = r_pll_resetb;
  assign bus.vid_rst    = r_vid_rst;
  assign bus.ready      = r_ready;
  assign bus.fault      = r_fault;
  assign bus.retries    = r_retries;

`ifdef VID_PLL_CTRL_STATS_EN
  logic [7:0] r_lock_loss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_loss_cnt <= 8'd0;
    end else if (r_state == RUN && !w_lock_s && r_lock_loss_cnt != 8'hFF) begin
      r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = r_lock_loss_cnt;
`endif

endmodule

// File: tb/tb_vid_pll_ctrl.sv
// Self-checking bench for vid_pll_ctrl: a run-length reference model
// predicts every output each cycle; directed scenarios pin literal
// timings, then randomized lock traffic exercises the rest.
module tb_vid_pll_ctrl;

  localparam int R  = 4;
  localparam int S  = 8;
  localparam int T  = 32;
  localparam int RM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vid_pll_ctrl_if bus ();

  vid_pll_ctrl #(
    .RST_CYCLES     (R),
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T),
    .RETRY_MAX      (RM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: outputs derived from run lengths of the
  // synchronised lock signal and a countdown of the reset pulse.
  bit started = 0;
  bit m_resetb, m_ready, m_fault;
  int m_left, m_lock_run, m_unlock_run, m_retries, m_loss;
  bit d1, d2, ls;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_resetb = 0; m_ready = 0; m_fault = 0;
      m_left = R; m_lock_run = 0; m_unlock_run = 0;
      m_retries = 0; m_loss = 0;
      d1 = 0; d2 = 0;
      cyc = 0;
    end else begin
      cyc++;
      ls = d2; d2 = d1; d1 = bus.pll_locked;
      if (m_fault) begin
        // parked
      end else if (!m_resetb) begin
        m_left--;
        if (m_left == 0) begin
          m_resetb = 1; m_lock_run = 0; m_unlock_run = 0;
        end
      end else if (m_ready) begin
        if (!ls) begin
          m_ready = 0; m_resetb = 0; m_left = R;
          if (m_loss < 255) m_loss++;
        end
      end else if (ls) begin
        m_lock_run++;
        m_unlock_run = 0;
        if (m_lock_run == S + 1) begin
          m_ready = 1; m_retries = 0;
        end
      end else if (m_lock_run > 0) begin
        // first unlocked sample after a partial lock only restarts the wait
        m_lock_run = 0; m_unlock_run = 0;
      end else begin
        m_unlock_run++;
        if (m_unlock_run == T) begin
          m_retries++;
          m_resetb = 0; m_left = R; m_unlock_run = 0;
          if (m_retries == RM) m_fault = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("pll_resetb", int'(bus.pll_resetb), int'(m_resetb));
      chk("vid_rst",    int'(bus.vid_rst),    int'(!m_ready));
      chk("ready",      int'(bus.ready),      int'(m_ready));
      chk("fault",      int'(bus.fault),      int'(m_fault));
      chk("retries",    int'(bus.retries),    m_retries);
`ifdef VID_PLL_CTRL_STATS_EN
      chk("lock_loss_cnt", int'(bus.lock_loss_cnt), m_loss);
`endif
    end
  end

  function automatic bit get_sig(input int sel);
    case (sel)
      0:       return bus.pll_resetb;
      1:       return bus.vid_rst;
      2:       return bus.ready;
      default: return bus.fault;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input int sel, input bit val, input int bound,
                          input string name, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (get_sig(sel) == val) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL %s timeout: no value %0d within %0d cycles", name, val, bound);
    end
  endtask

  task automatic do_reset(input bit lk);
    @(posedge clk);
    #1;
    rst = 1;
    bus.pll_locked = lk;
    step(2);
    rst = 0;
  endtask

  int at, at2, k;
  bit lk;

  initial begin
    bus.pll_locked = 0;
    rst = 1;

    // reset state
    step(2);
    @(negedge clk);
    chk("rst_resetb", int'(bus.pll_resetb), 0);
    chk("rst_vid_rst", int'(bus.vid_rst), 1);
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_retries", int'(bus.retries), 0);

    // clean bring-up
    do_reset(0);
    wait_for(0, 1, 20, "bringup_resetb", at);
    chk("bringup_resetb_cyc", at, 4);
    step_to(9);
    bus.pll_locked = 1;
    wait_for(2, 1, 60, "bringup_ready", at);
    chk("bringup_ready_cyc", at, 20);
    chk("bringup_retries", int'(bus.retries), 0);

    // unstable lock
    do_reset(0);
    wait_for(0, 1, 20, "unstable_resetb", at);
    step_to(6);
    bus.pll_locked = 1; step(5);
    bus.pll_locked = 0; step(3);
    bus.pll_locked = 1;
    k = cyc;
    wait_for(2, 1, 60, "unstable_ready", at);
    chk("unstable_ready_cyc", at, k + 11);

    // lock loss in RUN
    step(2);
    bus.pll_locked = 0;
    k = cyc;
    wait_for(1, 1, 10, "loss_vid_rst", at);
    chk("loss_vid_rst_cyc", at, k + 3);
    wait_for(0, 1, 20, "loss_resetb", at2);
    chk("loss_resetb_low_cycles", at2 - at, R);
`ifdef VID_PLL_CTRL_STATS_EN
    chk("loss_cnt_one", int'(bus.lock_loss_cnt), 1);
`endif
    bus.pll_locked = 1;
    wait_for(2, 1, 60, "loss_relock_ready", at);

    // timeout / retry into FAULT
    do_reset(0);
    for (int p = 1; p <= 3; p++) begin
      wait_for(0, 1, 60, "retry_resetb_hi", at);
      wait_for(0, 0, 60, "retry_resetb_lo", at);
      chk("retry_count", int'(bus.retries), p);
    end
    chk("fault_cyc", at, 108);
    chk("fault_set", int'(bus.fault), 1);
    step(50);
    chk("fault_sticky", int'(bus.fault), 1);
    chk("fault_retries", int'(bus.retries), 3);
    chk("fault_resetb", int'(bus.pll_resetb), 0);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("fault_rst_fault", int'(bus.fault), 0);
    chk("fault_rst_retries", int'(bus.retries), 0);
    chk("fault_rst_vid_rst", int'(bus.vid_rst), 1);

    // lock on the exact timeout cycle
    do_reset(0);
    step_to(33);
    bus.pll_locked = 1;
    wait_for(2, 1, 60, "boundary_ready", at);
    chk("boundary_ready_cyc", at, 44);
    chk("boundary_retries", int'(bus.retries), 0);

    // reset in the middle of STABLE
    do_reset(0);
    step_to(9);
    bus.pll_locked = 1;
    step_to(14);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_resetb", int'(bus.pll_resetb), 0);
    chk("midrst_vid_rst", int'(bus.vid_rst), 1);
    rst = 0;
    wait_for(0, 1, 20, "midrst_resetb_rise", at);
    chk("midrst_resetb_cyc", at, 4);

    // repeated lock losses, randomized spacing
    for (int i = 0; i < 300; i++) begin
      wait_for(2, 1, 100, "sat_ready", at);
      step($urandom_range(0, 4));
      bus.pll_locked = 0;
      wait_for(1, 1, 10, "sat_vid_rst", at);
      step($urandom_range(0, 6));
      bus.pll_locked = 1;
    end
    wait_for(2, 1, 100, "sat_final_ready", at);
`ifdef VID_PLL_CTRL_STATS_EN
    chk("loss_cnt_saturated", int'(bus.lock_loss_cnt), 255);
`endif

    // randomized lock traffic with occasional resets
    do_reset(0);
    lk = 0;
    for (int r = 0; r < 150; r++) begin
      lk = !lk;
      bus.pll_locked = lk;
      step($urandom_range(1, 45));
      if ($urandom_range(0, 20) == 0) begin
        rst = 1;
        step(1);
        rst = 0;
      end
    end
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
